tl45_issue_ctrl: RTL and testbench
==================================

// Module: tl45_issue_ctrl
// PURPOSE
//  Issue/hazard controller between decode and tl45_alu. Holds one decoded instruction in an issue buffer.
//  Resolves source operands by forwarding from the ALU and MEM stages. Tracks outstanding loads in a register
//  scoreboard, and inserts bubbles/stalls for RAW and WAW hazards.
// PARAMETERS
//  XLEN      32  datapath width
//  NREG      16  architectural registers (r0 reads 0, never written)
//  MAX_LOADS 2   max loads in flight past the ALU; counter width $clog2(MAX_LOADS+1)
// PORTS
//  i_clk            in   1     clock
//  i_reset          in   1     synchronous, active-high reset
//  i_pipe_stall     in   1     stall from tl45_alu (o_pipe_stall)
//  i_pipe_flush     in   1     flush from tl45_alu (o_pipe_flush)
//  o_pipe_stall     out  1     stall to decode
//  o_pipe_flush     out  1     flush to decode (= i_pipe_flush)
//  i_opcode         in   5     decoded opcode; 0 = NOP
//  i_is_load        in   1     instruction's dr is written by memory, not ALU
//  i_dr,i_sr1,i_sr2 in   4     dest / source register ids
//  i_sr1_val,i_sr2_val in XLEN regfile read values
//  i_jmp_cond       in   4     branch condition
//  i_target_offset,i_pc in XLEN passed through
//  i_alu_of_reg     in   4     ALU forward reg (0 = none)
//  i_alu_of_val     in   XLEN  ALU forward value
//  i_mem_of_valid   in   1     load data returning this cycle
//  i_mem_of_reg     in   4     returning load's dest reg
//  i_mem_of_val     in   XLEN  returning load data
//  o_opcode,o_dr,o_jmp_cond,o_sr1_val,o_sr2_val,o_target_offset,o_pc  out  issue buffer to tl45_alu
//  o_stall_cycles   out  32    saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset:
//  - all o_* buffer fields 0 (NOP); scoreboard 0; load counter 0; o_stall_cycles 0
//  - loads in flight at reset are discarded; a later i_mem_of_valid with counter 0 is ignored (no underflow)
//  Handoff:
//  - buffer instruction enters ALU on a cycle with !i_pipe_stall && !i_pipe_flush
//  - if it is a load with o_dr!=0, set sb[o_dr] and increment the counter
//  Load completion:
//  - i_mem_of_valid clears sb[i_mem_of_reg] and decrements the counter
//  - handoff and completion in the same cycle leave the counter unchanged
//  Hazard (combinational, for the incoming instruction only; opcode 0 and source r0 never hazard). Stall if any:
//  - a source equals buffer o_dr!=0, with the buffer holding a non-NOP. One-bubble RAW rule: that result is not yet computed.
//  - a source has sb set and is not being returned this cycle by i_mem_of
//  - i_is_load && (sb[i_dr] set || counter==MAX_LOADS); WAW / capacity
//  Operand select, priority high to low: r0 -> 0; i_alu_of_reg match -> i_alu_of_val; i_mem_of match -> i_mem_of_val; else regfile value
//  Outputs:
//  - o_pipe_stall = i_pipe_stall | hazard
//  - buffer update, priority high to low:
//    - reset or i_pipe_flush -> NOP
//    - i_pipe_stall -> hold
//    - hazard -> load NOP (bubble)
//    - otherwise -> latch the incoming instruction with resolved operands
//  - o_stall_cycles increments on each cycle with hazard && !i_pipe_stall; saturates at 32'hFFFFFFFF
//  Latency: 1 cycle, decode to ALU input, when no hazard
// STRUCTURE
//  - tl45_pkg: opcode localparams (OP_NOP=0, OP_ADD, ...), REG_ZERO, XLEN/NREG defaults
//  - sub-module tl45_scoreboard: NREG-bit pending vector and load counter; set/clear/query ports
//  - issue buffer, forwarding muxes and hazard logic stay in tl45_issue_ctrl
// TESTING
//  1. Reset, then ADD r1<-r2,r3 with regfile values 5 and 7 -> next cycle o_opcode=1, o_sr1_val=5, o_sr2_val=7; o_pipe_stall=0.
//  2. ADD r1 then SUB r4<-r1,r2 back-to-back -> 1 bubble (o_opcode=0 one cycle).
//     SUB then issues with o_sr1_val=i_alu_of_val=0x1234; o_stall_cycles=1.
//  3. LOAD r5, then ADD using r5 -> stall until i_mem_of_valid with reg 5 and value 0xCAFE.
//     ADD issues that cycle with o_sr1_val=0xCAFE; sb[5]=0 afterwards.
//  4. MAX_LOADS=2: three loads to r1,r2,r3 with no return -> third load stalls.
//     Return for r1 -> r3 issues the same cycle; counter stays 2.
//  5. i_pipe_flush while buffer holds a LOAD r6 -> buffer becomes NOP; sb[6] stays 0; counter unchanged.
//  6. Reset asserted with 2 loads pending, then i_mem_of_valid for r2 -> counter stays 0; sb all 0.
//     Sources using r0 never stall and read 0.

Source files
------------

// File: rtl/tl45_pkg.sv
// Shared definitions for the tl45 issue/hazard slice: datapath defaults,
// opcode encodings and a register-match helper.
package tl45_pkg;

  localparam int TL45_XLEN      = 32;
  localparam int TL45_NREG      = 16;
  localparam int TL45_MAX_LOADS = 2;
  localparam int REG_W          = 4;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_LOAD = 5'd3;
  localparam logic [4:0] OP_STOR = 5'd4;
  localparam logic [4:0] OP_JMP  = 5'd5;

  // True when a real (non-r0) source register equals the other id.
  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] other);
    return (src != REG_ZERO) && (src == other);
  endfunction

endpackage

// File: rtl/tl45_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register whose value
// is still owed by memory, plus a count of loads in flight past the ALU.
module tl45_scoreboard
  import tl45_pkg::*;
#(
  parameter int MAX_LOADS = TL45_MAX_LOADS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_set_valid,
  input  logic [REG_W-1:0]     i_set_reg,
  input  logic                 i_clr_valid,
  input  logic [REG_W-1:0]     i_clr_reg,
  output logic [TL45_NREG-1:0] o_pending,
  output logic                 o_full
);

  localparam int CW = $clog2(MAX_LOADS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOADS);

  logic [TL45_NREG-1:0] r_pending;
  logic [CW-1:0]        r_count;
  logic                 w_set_en;
  logic                 w_clr_en;

  // A return with nothing in flight belongs to a load discarded by reset.
  assign w_clr_en = i_clr_valid && (r_count != '0);
  assign w_set_en = i_set_valid && (i_set_reg != REG_ZERO);

  // A load returning this cycle frees its slot for an incoming load.
  assign o_full    = (r_count == MAX_CNT) && !w_clr_en;
  assign o_pending = r_pending;

  // Track pending destinations and the in-flight load count.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // NOTE: the pending vector is a handful of flops, not a RAM, so it is
      // cleared on reset to drop loads that were in flight.
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      if (w_clr_en) r_pending[i_clr_reg] <= 1'b0;
      if (w_set_en) r_pending[i_set_reg] <= 1'b1;
      case ({w_set_en, w_clr_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tl45_issue_ctrl.sv
// Issue/hazard controller between decode and tl45_alu: one-entry issue
// buffer, operand forwarding from ALU/MEM, RAW/WAW/capacity stalls.
module tl45_issue_ctrl
  import tl45_pkg::*;
#(
  parameter int XLEN      = TL45_XLEN,
  parameter int MAX_LOADS = TL45_MAX_LOADS
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pipe_stall,
  input  logic             i_pipe_flush,
  output logic             o_pipe_stall,
  output logic             o_pipe_flush,
  input  logic [4:0]       i_opcode,
  input  logic             i_is_load,
  input  logic [REG_W-1:0] i_dr,
  input  logic [REG_W-1:0] i_sr1,
  input  logic [REG_W-1:0] i_sr2,
  input  logic [XLEN-1:0]  i_sr1_val,
  input  logic [XLEN-1:0]  i_sr2_val,
  input  logic [3:0]       i_jmp_cond,
  input  logic [XLEN-1:0]  i_target_offset,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [REG_W-1:0] i_alu_of_reg,
  input  logic [XLEN-1:0]  i_alu_of_val,
  input  logic             i_mem_of_valid,
  input  logic [REG_W-1:0] i_mem_of_reg,
  input  logic [XLEN-1:0]  i_mem_of_val,
  output logic [4:0]       o_opcode,
  output logic [REG_W-1:0] o_dr,
  output logic [3:0]       o_jmp_cond,
  output logic [XLEN-1:0]  o_sr1_val,
  output logic [XLEN-1:0]  o_sr2_val,
  output logic [XLEN-1:0]  o_target_offset,
  output logic [XLEN-1:0]  o_pc,
  output logic [31:0]      o_stall_cycles
);

  logic [4:0]           r_opcode;
  logic                 r_is_load;
  logic [REG_W-1:0]     r_dr;
  logic [3:0]           r_jmp_cond;
  logic [XLEN-1:0]      r_sr1_val;
  logic [XLEN-1:0]      r_sr2_val;
  logic [XLEN-1:0]      r_target_offset;
  logic [XLEN-1:0]      r_pc;
  logic [31:0]          r_stall_cycles;

  logic [TL45_NREG-1:0] w_pending;
  logic                 w_full;
  logic                 w_handoff;
  logic                 w_sb_set;
  logic                 w_buf_busy;
  logic                 w_sr1_hz;
  logic                 w_sr2_hz;
  logic                 w_waw_hz;
  logic                 w_hazard;
  logic [XLEN-1:0]      w_sr1_fwd;
  logic [XLEN-1:0]      w_sr2_fwd;

  // The buffered instruction leaves for the ALU whenever the ALU accepts it.
  assign w_handoff = !i_pipe_stall && !i_pipe_flush;
  assign w_sb_set  = w_handoff && r_is_load && (r_dr != REG_ZERO);

  tl45_scoreboard #(
    .MAX_LOADS (MAX_LOADS)
  ) u_sb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_set_valid (w_sb_set),
    .i_set_reg   (r_dr),
    .i_clr_valid (i_mem_of_valid),
    .i_clr_reg   (i_mem_of_reg),
    .o_pending   (w_pending),
    .o_full      (w_full)
  );

  // The buffered result is computed only after it leaves, so a dependent
  // instruction directly behind it needs one bubble.
  assign w_buf_busy = (r_opcode != OP_NOP) && (r_dr != REG_ZERO);

  assign w_sr1_hz = (i_sr1 != REG_ZERO) &&
                    ((w_buf_busy && (i_sr1 == r_dr)) ||
                     (w_pending[i_sr1] && !(i_mem_of_valid && (i_mem_of_reg == i_sr1))));
  assign w_sr2_hz = (i_sr2 != REG_ZERO) &&
                    ((w_buf_busy && (i_sr2 == r_dr)) ||
                     (w_pending[i_sr2] && !(i_mem_of_valid && (i_mem_of_reg == i_sr2))));
  assign w_waw_hz = i_is_load && (w_pending[i_dr] || w_full);
  assign w_hazard = (i_opcode != OP_NOP) && (w_sr1_hz || w_sr2_hz || w_waw_hz);

  assign o_pipe_stall = i_pipe_stall | w_hazard;
  assign o_pipe_flush = i_pipe_flush;

  // Resolve each source: r0, then ALU forward, then MEM forward, then regfile.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the if-chain leaves it unassigned and infers a latch.
    w_sr1_fwd = i_sr1_val;
    w_sr2_fwd = i_sr2_val;
    if (i_sr1 == REG_ZERO)                           w_sr1_fwd = '0;
    else if (reg_hit(i_sr1, i_alu_of_reg))           w_sr1_fwd = i_alu_of_val;
    else if (i_mem_of_valid && reg_hit(i_sr1, i_mem_of_reg)) w_sr1_fwd = i_mem_of_val;
    if (i_sr2 == REG_ZERO)                           w_sr2_fwd = '0;
    else if (reg_hit(i_sr2, i_alu_of_reg))           w_sr2_fwd = i_alu_of_val;
    else if (i_mem_of_valid && reg_hit(i_sr2, i_mem_of_reg)) w_sr2_fwd = i_mem_of_val;
  end

  // Issue buffer: flush beats hold, hold beats bubble, bubble beats latch.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_pipe_flush || (!i_pipe_stall && w_hazard)) begin
      r_opcode        <= OP_NOP;
      r_is_load       <= 1'b0;
      r_dr            <= REG_ZERO;
      r_jmp_cond      <= '0;
      r_sr1_val       <= '0;
      r_sr2_val       <= '0;
      r_target_offset <= '0;
      r_pc            <= '0;
    end else if (!i_pipe_stall) begin
      r_opcode        <= i_opcode;
      r_is_load       <= i_is_load;
      r_dr            <= i_dr;
      r_jmp_cond      <= i_jmp_cond;
      r_sr1_val       <= w_sr1_fwd;
      r_sr2_val       <= w_sr2_fwd;
      r_target_offset <= i_target_offset;
      r_pc            <= i_pc;
    end
  end

  // Saturating count of cycles lost to our own hazards.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cycles <= '0;
    end else if (w_hazard && !i_pipe_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_opcode        = r_opcode;
  assign o_dr            = r_dr;
  assign o_jmp_cond      = r_jmp_cond;
  assign o_sr1_val       = r_sr1_val;
  assign o_sr2_val       = r_sr2_val;
  assign o_target_offset = r_target_offset;
  assign o_pc            = r_pc;
  assign o_stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_tl45_issue_ctrl.sv
// Directed bench for tl45_issue_ctrl: forwarding, RAW bubble, load
// scoreboard, load capacity, flush/hold and reset of in-flight loads.
module tb_tl45_issue_ctrl;
  import tl45_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_pipe_stall, i_pipe_flush;
  logic        o_pipe_stall, o_pipe_flush;
  logic [4:0]  i_opcode;
  logic        i_is_load;
  logic [3:0]  i_dr, i_sr1, i_sr2;
  logic [31:0] i_sr1_val, i_sr2_val;
  logic [3:0]  i_jmp_cond;
  logic [31:0] i_target_offset, i_pc;
  logic [3:0]  i_alu_of_reg;
  logic [31:0] i_alu_of_val;
  logic        i_mem_of_valid;
  logic [3:0]  i_mem_of_reg;
  logic [31:0] i_mem_of_val;
  logic [4:0]  o_opcode;
  logic [3:0]  o_dr, o_jmp_cond;
  logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc, o_stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  tl45_issue_ctrl dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_pipe_stall    (i_pipe_stall),
    .i_pipe_flush    (i_pipe_flush),
    .o_pipe_stall    (o_pipe_stall),
    .o_pipe_flush    (o_pipe_flush),
    .i_opcode        (i_opcode),
    .i_is_load       (i_is_load),
    .i_dr            (i_dr),
    .i_sr1           (i_sr1),
    .i_sr2           (i_sr2),
    .i_sr1_val       (i_sr1_val),
    .i_sr2_val       (i_sr2_val),
    .i_jmp_cond      (i_jmp_cond),
    .i_target_offset (i_target_offset),
    .i_pc            (i_pc),
    .i_alu_of_reg    (i_alu_of_reg),
    .i_alu_of_val    (i_alu_of_val),
    .i_mem_of_valid  (i_mem_of_valid),
    .i_mem_of_reg    (i_mem_of_reg),
    .i_mem_of_val    (i_mem_of_val),
    .o_opcode        (o_opcode),
    .o_dr            (o_dr),
    .o_jmp_cond      (o_jmp_cond),
    .o_sr1_val       (o_sr1_val),
    .o_sr2_val       (o_sr2_val),
    .o_target_offset (o_target_offset),
    .o_pc            (o_pc),
    .o_stall_cycles  (o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs and checks both happen 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_pipe_stall = 0; i_pipe_flush = 0;
    i_opcode = OP_NOP; i_is_load = 0; i_dr = 0; i_sr1 = 0; i_sr2 = 0;
    i_sr1_val = 0; i_sr2_val = 0; i_jmp_cond = 0; i_target_offset = 0; i_pc = 0;
    i_alu_of_reg = 0; i_alu_of_val = 0;
    i_mem_of_valid = 0; i_mem_of_reg = 0; i_mem_of_val = 0;
  endtask

  task automatic drive(input logic [4:0] op, input logic ld, input logic [3:0] dr,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [31:0] v1, input logic [31:0] v2);
    i_opcode = op; i_is_load = ld; i_dr = dr; i_sr1 = s1; i_sr2 = s2;
    i_sr1_val = v1; i_sr2_val = v2;
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1;
    tick(); tick();
    i_reset = 0;
  endtask

  initial begin
    i_reset = 1;
    idle();
    tick();

    // 1: reset state, then plain ADD r1 <- r2, r3
    do_reset();
    check("rst_opcode", 32'(o_opcode), 32'h0);
    check("rst_dr", 32'(o_dr), 32'h0);
    check("rst_sr1", o_sr1_val, 32'h0);
    check("rst_stall_cycles", o_stall_cycles, 32'h0);
    check("rst_load_count", 32'(dut.u_sb.r_count), 32'h0);
    drive(OP_ADD, 0, 4'd1, 4'd2, 4'd3, 32'd5, 32'd7);
    i_pc = 32'h100; i_target_offset = 32'h40; i_jmp_cond = 4'h3;
    #1 check("add_no_stall", 32'(o_pipe_stall), 32'h0);
    tick();
    check("add_opcode", 32'(o_opcode), 32'h1);
    check("add_dr", 32'(o_dr), 32'h1);
    check("add_sr1", o_sr1_val, 32'd5);
    check("add_sr2", o_sr2_val, 32'd7);
    check("add_pc", o_pc, 32'h100);
    check("add_target", o_target_offset, 32'h40);
    check("add_jmp_cond", 32'(o_jmp_cond), 32'h3);

    // 2: SUB r4 <- r1, r2 right behind ADD r1 -> one bubble, then ALU forward
    idle();
    drive(OP_SUB, 0, 4'd4, 4'd1, 4'd2, 32'hDEAD, 32'd2);
    #1 check("raw_stall", 32'(o_pipe_stall), 32'h1);
    tick();
    check("raw_bubble_opcode", 32'(o_opcode), 32'h0);
    i_alu_of_reg = 4'd1; i_alu_of_val = 32'h1234;
    #1 check("raw_released", 32'(o_pipe_stall), 32'h0);
    tick();
    check("sub_opcode", 32'(o_opcode), 32'h2);
    check("sub_dr", 32'(o_dr), 32'h4);
    check("sub_sr1_alu_fwd", o_sr1_val, 32'h1234);
    check("sub_sr2", o_sr2_val, 32'd2);
    check("raw_stall_cycles", o_stall_cycles, 32'd1);

    // 3: LOAD r5, then ADD r6 <- r5, r0 waits for the memory return
    do_reset();
    drive(OP_LOAD, 1, 4'd5, 4'd1, 4'd0, 32'h10, 32'h0);
    tick();
    check("ld5_opcode", 32'(o_opcode), 32'(OP_LOAD));
    drive(OP_ADD, 0, 4'd6, 4'd5, 4'd0, 32'h1111, 32'h2222);
    #1 check("ld_use_raw_stall", 32'(o_pipe_stall), 32'h1);
    tick();
    check("ld_use_bubble", 32'(o_opcode), 32'h0);
    check("sb5_set", 32'(dut.u_sb.r_pending[5]), 32'h1);
    check("ld_count_1", 32'(dut.u_sb.r_count), 32'h1);
    #1 check("sb_stall", 32'(o_pipe_stall), 32'h1);
    tick();
    check("sb_stall_opcode", 32'(o_opcode), 32'h0);
    check("ld_stall_cycles", o_stall_cycles, 32'd2);
    i_mem_of_valid = 1; i_mem_of_reg = 4'd5; i_mem_of_val = 32'hCAFE;
    #1 check("mem_ret_no_stall", 32'(o_pipe_stall), 32'h0);
    tick();
    check("ld_use_opcode", 32'(o_opcode), 32'h1);
    check("ld_use_sr1_mem_fwd", o_sr1_val, 32'hCAFE);
    check("ld_use_sr2_r0", o_sr2_val, 32'h0);
    check("sb5_cleared", 32'(dut.u_sb.r_pending[5]), 32'h0);
    check("ld_count_0", 32'(dut.u_sb.r_count), 32'h0);
    check("ld_stall_cycles_hold", o_stall_cycles, 32'd2);

    // 4: load capacity of two; a return frees a slot the same cycle
    do_reset();
    drive(OP_LOAD, 1, 4'd1, 4'd0, 4'd0, 0, 0); tick();
    drive(OP_LOAD, 1, 4'd2, 4'd0, 4'd0, 0, 0); tick();
    idle(); tick();
    check("cap_count_2", 32'(dut.u_sb.r_count), 32'h2);
    check("cap_pending", 32'(dut.u_sb.r_pending), 32'h0006);
    drive(OP_LOAD, 1, 4'd3, 4'd0, 4'd0, 0, 0);
    #1 check("cap_stall", 32'(o_pipe_stall), 32'h1);
    tick();
    check("cap_bubble", 32'(o_opcode), 32'h0);
    i_mem_of_valid = 1; i_mem_of_reg = 4'd1; i_mem_of_val = 32'h77;
    #1 check("cap_freed", 32'(o_pipe_stall), 32'h0);
    tick();
    check("cap_ld3_opcode", 32'(o_opcode), 32'(OP_LOAD));
    check("cap_ld3_dr", 32'(o_dr), 32'h3);
    idle(); tick();
    check("cap_count_stays_2", 32'(dut.u_sb.r_count), 32'h2);
    check("cap_pending_after", 32'(dut.u_sb.r_pending), 32'h000C);
    check("cap_stall_cycles", o_stall_cycles, 32'd1);

    // 5a: downstream stall holds the buffer and never counts as our stall
    do_reset();
    drive(OP_ADD, 0, 4'd1, 4'd2, 4'd3, 32'd9, 32'd8); tick();
    drive(OP_SUB, 0, 4'd4, 4'd1, 4'd2, 32'd0, 32'd0);
    i_pipe_stall = 1;
    #1 check("hold_stall_out", 32'(o_pipe_stall), 32'h1);
    tick();
    check("hold_opcode", 32'(o_opcode), 32'h1);
    check("hold_sr1", o_sr1_val, 32'd9);
    check("hold_no_count", o_stall_cycles, 32'd0);

    // 5b: flush while the buffer holds LOAD r6
    do_reset();
    drive(OP_LOAD, 1, 4'd6, 4'd0, 4'd0, 0, 0); tick();
    idle();
    i_pipe_flush = 1;
    #1 check("flush_passthru", 32'(o_pipe_flush), 32'h1);
    tick();
    check("flush_opcode", 32'(o_opcode), 32'h0);
    check("flush_dr", 32'(o_dr), 32'h0);
    check("flush_sb6", 32'(dut.u_sb.r_pending[6]), 32'h0);
    check("flush_count", 32'(dut.u_sb.r_count), 32'h0);

    // 6: reset discards in-flight loads; stale return is ignored; r0 reads 0
    do_reset();
    drive(OP_LOAD, 1, 4'd1, 4'd0, 4'd0, 0, 0); tick();
    drive(OP_LOAD, 1, 4'd2, 4'd0, 4'd0, 0, 0); tick();
    idle(); tick();
    check("pre_rst_count", 32'(dut.u_sb.r_count), 32'h2);
    do_reset();
    i_mem_of_valid = 1; i_mem_of_reg = 4'd2; i_mem_of_val = 32'h55;
    tick();
    check("stale_ret_count", 32'(dut.u_sb.r_count), 32'h0);
    check("stale_ret_pending", 32'(dut.u_sb.r_pending), 32'h0);
    idle();
    drive(OP_ADD, 0, 4'd7, 4'd0, 4'd0, 32'hAA, 32'hBB);
    i_alu_of_reg = 4'd0; i_alu_of_val = 32'h99;
    #1 check("r0_no_stall", 32'(o_pipe_stall), 32'h0);
    tick();
    check("r0_sr1", o_sr1_val, 32'h0);
    check("r0_sr2", o_sr2_val, 32'h0);
    check("r0_dr", 32'(o_dr), 32'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
